// File: rtl/eca_if.sv
// Configuration/status bundle for eca_array_engine.
// ECA_POPCOUNT_EN adds the pop_count status signal.
interface eca_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GEN_W = 16
) ();
  localparam int unsigned PW = $clog2(WIDTH + 1);

  logic             rule_we;
  logic [7:0]       rule_in;
  logic             seed_valid;
  logic             seed_ready;
  logic [WIDTH-1:0] seed_data;
  logic             run;
  logic [GEN_W-1:0] steps;
  logic             halt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] cells;
  logic [GEN_W-1:0] gen_count;
`ifdef ECA_POPCOUNT_EN
  logic [PW-1:0]    pop_count;
`endif

  modport master (
    output rule_we, rule_in, seed_valid, seed_data, run, steps, halt,
    input  seed_ready, busy, done, cells, gen_count
`ifdef ECA_POPCOUNT_EN
    , input pop_count
`endif
  );

  modport slave (
    input  rule_we, rule_in, seed_valid, seed_data, run, steps, halt,
    output seed_ready, busy, done, cells, gen_count
`ifdef ECA_POPCOUNT_EN
    , output pop_count
`endif
  );
endinterface

// File: rtl/eca_array_engine.sv
// WIDTH-cell elementary cellular automaton with loadable 8-bit rule and step counter.
// Optional ECA_POPCOUNT_EN adds a registered population count of the cell vector.
module eca_array_engine #(
  parameter int unsigned WIDTH      = 16,
  parameter logic [7:0]  RULE_RESET = 8'h4C,
  parameter int unsigned WRAP       = 1,
  parameter int unsigned GEN_W      = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  eca_if.slave  bus
);
  localparam int unsigned PW = $clog2(WIDTH + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cells, w_cells_nxt;
  logic [7:0]       r_rule, w_rule_nxt;
  logic [GEN_W-1:0] r_gen, w_gen_nxt;
  logic [GEN_W-1:0] r_rem, w_rem_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_seed_ready, w_seed_ready_nxt;

  logic [WIDTH+1:0] w_ext;
  logic [WIDTH-1:0] w_gen_cells;
  logic             w_seed_xfer;

  // Neighbourhood vector: one boundary bit beyond each end of the array.
  assign w_ext = {(WRAP != 0) ? r_cells[0] : 1'b0,
                  r_cells,
                  (WRAP != 0) ? r_cells[WIDTH-1] : 1'b0};

  always_comb begin
    logic [2:0] w_pat;
    w_gen_cells = '0;
    w_pat       = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_pat          = w_ext[i +: 3];
      w_gen_cells[i] = r_rule[3'd7 - w_pat];
    end
  end

  assign w_seed_xfer = bus.seed_valid && r_seed_ready;

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cells_nxt = r_cells;
    w_rule_nxt  = r_rule;
    w_gen_nxt   = r_gen;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rule_we) w_rule_nxt = bus.rule_in;
        if (w_seed_xfer) begin
          w_cells_nxt = bus.seed_data;
          w_gen_nxt   = '0;
        end
        if (bus.run) begin
          if (bus.steps == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_rem_nxt   = bus.steps;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.halt) begin
          w_rem_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cells_nxt = w_gen_cells;
          w_gen_nxt   = (r_gen == '1) ? r_gen : r_gen + GEN_W'(1);
          w_rem_nxt   = r_rem - GEN_W'(1);
          if (r_rem == GEN_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt       = (w_state_nxt == S_RUN);
    w_seed_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cells      <= '0;
      r_rule       <= RULE_RESET;
      r_gen        <= '0;
      r_rem        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_seed_ready <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cells      <= w_cells_nxt;
      r_rule       <= w_rule_nxt;
      r_gen        <= w_gen_nxt;
      r_rem        <= w_rem_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_seed_ready <= w_seed_ready_nxt;
    end
  end

  assign bus.seed_ready = r_seed_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.cells      = r_cells;
  assign bus.gen_count  = r_gen;

`ifdef ECA_POPCOUNT_EN
  logic [PW-1:0] r_pop, w_pop_nxt;

  // Counts the vector being written so the count tracks cells on the same edge.
  always_comb begin
    w_pop_nxt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_pop_nxt = w_pop_nxt + PW'(w_cells_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_pop <= '0;
    else        r_pop <= w_pop_nxt;
  end

  assign bus.pop_count = r_pop;
`endif
endmodule

// File: tb/tb_eca_array_engine.sv
// Scoreboard bench for eca_array_engine: 8-cell toroidal DUT plus a WRAP=0 twin on shared inputs.
module tb_eca_array_engine;
  localparam int unsigned W  = 8;
  localparam int unsigned GW = 16;

  typedef struct {
    logic [W-1:0]  cells;
    logic [GW-1:0] gen;
    logic [W-1:0]  cells0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  eca_if #(.WIDTH(W), .GEN_W(GW)) bus ();
  eca_if #(.WIDTH(W), .GEN_W(GW)) bus0 ();

  eca_array_engine #(.WIDTH(W), .RULE_RESET(8'h4C), .WRAP(1), .GEN_W(GW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  eca_array_engine #(.WIDTH(W), .RULE_RESET(8'h4C), .WRAP(0), .GEN_W(GW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  assign bus0.rule_we    = bus.rule_we;
  assign bus0.rule_in    = bus.rule_in;
  assign bus0.seed_valid = bus.seed_valid;
  assign bus0.seed_data  = bus.seed_data;
  assign bus0.run        = bus.run;
  assign bus0.steps      = bus.steps;
  assign bus0.halt       = bus.halt;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.rule_we = 0; bus.rule_in = '0; bus.seed_valid = 0; bus.seed_data = '0;
    bus.run = 0; bus.steps = '0; bus.halt = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk("run_timeout", 32'(bus.busy), 32'd0);
  endtask

  // Monitor: every done pulse retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done) begin
        chk("done_twin", 32'(bus0.done), 32'd1);
        chk("done_back_to_back", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cells", 32'(bus.cells), 32'(e.cells));
          chk("done_gen", 32'(bus.gen_count), 32'(e.gen));
          chk("done_cells_nowrap", 32'(bus0.cells), 32'(e.cells0));
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] v5a [3];
    v5a[0] = 8'h28; v5a[1] = 8'h44; v5a[2] = 8'hAA;
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    chk("rst_cells", 32'(bus.cells), 32'd0);
    chk("rst_gen", 32'(bus.gen_count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_seed_ready", 32'(bus.seed_ready), 32'd1);
    rst_n = 1;

    // Seed and run on the same edge, reset rule 0x4C, one step.
    bus.seed_valid = 1; bus.seed_data = 8'h01; bus.run = 1; bus.steps = 16'd1;
    sb.push_back('{cells: 8'h82, gen: 16'd1, cells0: 8'h02});
    tick(); idle_inputs();
    chk("r1_busy", 32'(bus.busy), 32'd1);
    chk("r1_seed_ready", 32'(bus.seed_ready), 32'd0);
    wait_idle(); tick();

    // Rule 0x5A loaded together with seed and run; check every generation.
    bus.rule_we = 1; bus.rule_in = 8'h5A; bus.seed_valid = 1; bus.seed_data = 8'h10;
    bus.run = 1; bus.steps = 16'd3;
    sb.push_back('{cells: 8'hAA, gen: 16'd3, cells0: 8'hAA});
    tick(); idle_inputs();
    chk("r3_busy0", 32'(bus.busy), 32'd1);
    chk("r3_cells0", 32'(bus.cells), 32'h10);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r3_cells", 32'(bus.cells), 32'(v5a[k]));
      chk("r3_cells_nowrap", 32'(bus0.cells), 32'(v5a[k]));
      chk("r3_gen", 32'(bus.gen_count), 32'(k + 1));
      chk("r3_busy", 32'(bus.busy), (k < 2) ? 32'd1 : 32'd0);
    end
    tick();

    // Reseed, then zero-step run: immediate done, nothing moves.
    bus.seed_valid = 1; bus.seed_data = 8'h10;
    tick(); idle_inputs();
    chk("reseed_gen", 32'(bus.gen_count), 32'd0);
    bus.run = 1; bus.steps = 16'd0;
    sb.push_back('{cells: 8'h10, gen: 16'd0, cells0: 8'h10});
    tick(); idle_inputs();
    chk("z_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("z_busy2", 32'(bus.busy), 32'd0);
    chk("z_cells", 32'(bus.cells), 32'h10);

    // Five-step run halted in its third RUN cycle.
    bus.run = 1; bus.steps = 16'd5;
    tick(); idle_inputs();
    tick(); tick();
    bus.halt = 1;
    tick(); idle_inputs();
    chk("h_busy", 32'(bus.busy), 32'd0);
    chk("h_done", 32'(bus.done), 32'd0);
    chk("h_seed_ready", 32'(bus.seed_ready), 32'd1);
    chk("h_gen", 32'(bus.gen_count), 32'd2);
    chk("h_cells", 32'(bus.cells), 32'h44);
    tick();
    chk("h_done2", 32'(bus.done), 32'd0);

    // Seed/rule/run offered during RUN must be ignored.
    bus.seed_valid = 1; bus.seed_data = 8'h01;
    tick(); idle_inputs();
    bus.run = 1; bus.steps = 16'd4;
    tick();
    bus.seed_valid = 1; bus.seed_data = 8'hFF; bus.rule_we = 1; bus.rule_in = 8'h00;
    bus.run = 1; bus.steps = 16'd1;
    tick();
    chk("ign_seed_ready", 32'(bus.seed_ready), 32'd0);
    tick();
    chk("ign_seed_ready2", 32'(bus.seed_ready), 32'd0);
    idle_inputs();
    sb.push_back('{cells: 8'h00, gen: 16'd4, cells0: 8'h14});
    wait_idle(); tick();

    // Reset in the middle of a run restores rule 0x4C.
    bus.seed_valid = 1; bus.seed_data = 8'h01; bus.run = 1; bus.steps = 16'd4;
    tick(); idle_inputs();
    tick();
    rst_n = 0;
    tick();
    chk("mr_cells", 32'(bus.cells), 32'd0);
    chk("mr_gen", 32'(bus.gen_count), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_seed_ready", 32'(bus.seed_ready), 32'd1);
    rst_n = 1;
    bus.seed_valid = 1; bus.seed_data = 8'h01; bus.run = 1; bus.steps = 16'd2;
    sb.push_back('{cells: 8'h45, gen: 16'd2, cells0: 8'h05});
    tick(); idle_inputs();
    wait_idle();
    tick(); tick();

    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
